id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 16-bit WISC pipelined CPU.
- Takes the IF/ID instruction and drives the register-file read addresses combinationally.
- Latches the operands the register file returns, together with decoded control, into the EX stage.
- Detects load-use hazards (one-cycle stall plus bubble), honours branch flush, and freezes after HLT.

Parameters:
- DW, 16, datapath/instruction width
- RW, 4, register index width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  16  IF/ID instruction
- if_pc  in  16  PC+2 of that instruction
- flush  in  1  branch taken in EX; kill the ID contents
- SrcReg1  out  4  register-file read address 1 (combinational)
- SrcReg2  out  4  register-file read address 2 (combinational)
- SrcData1  in  16  register-file read data 1 (already WB-bypassed)
- SrcData2  in  16  register-file read data 2
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- halted  out  1  HLT has entered EX; sticky
- ex_valid  out  1  EX slot holds a real instruction
- ex_opcode  out  4  opcode
- ex_rd  out  4  destination register
- ex_rs, ex_rt  out  4 each  source indices (for EX forwarding)
- ex_op1, ex_op2  out  16 each  latched operands
- ex_imm  out  16  extended immediate
- ex_pc  out  16  latched if_pc
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  controls

Behaviour:
- Fields: opcode = instr[15:12]; A = [11:8]; B = [7:4]; C = [3:0].
- Opcode values: 0–7 ALU (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB); 8 LW; 9 SW; A LLB; B LHB; C B; D BR; E PCS; F HLT.
- SrcReg1 = A for LLB/LHB, else B.
- SrcReg2 = A for SW, else C.
- uses1 = opcode in {0–B, D}.
- uses2 = opcode in {0, 1, 2, 3, 7, 9}.
- ex_rd = A.
- ex_reg_write = opcode in {0–8, A, B, E}; writes to R0 are allowed (no special case).
- ex_mem_read = LW; ex_mem_write = SW.
- ex_imm by opcode:
  - SLL/SRA/ROR: zero-extended C.
  - LW/SW: sign-extended C, shifted left by 1.
  - LLB/LHB: zero-extended instr[7:0].
  - B: sign-extended instr[8:0], shifted left by 1.
  - Otherwise: 0.
- load_use = ex_valid & ex_mem_read & ex_rd != 0 & if_valid & ((uses1 & SrcReg1 == ex_rd) | (uses2 & SrcReg2 == ex_rd)).
- stall = load_use & !flush & state == RUN.
- States:
  - RUN: normal operation.
  - BUBBLE: entered for exactly one cycle after a stall.
  - HALT: terminal until reset.
- Per-edge update, in priority order:
  1. Reset asserted: asynchronously clear every ex_* output and halted; state = RUN.
  2. HALT: hold all registers; ex_valid = 0 after the cycle that entered HALT.
  3. flush: ex_valid <= 0; state = RUN (flush overrides stall).
  4. stall: ex_valid <= 0 (bubble); other ex_* fields are don't-care but are cleared; state = BUBBLE.
  5. Otherwise: latch decode; ex_valid <= if_valid; state = RUN.
- BUBBLE never stalls again for the same instruction, because the load has left EX.
- When a valid HLT is latched into EX: halted <= 1 and state = HALT. stall stays 0 in HALT.
- Latency: instruction in ID at cycle n appears on ex_* at n+1, or n+2 if stalled.
- Operands are taken from SrcData at the latching edge. Same-cycle WB bypass is the register file's responsibility.
- Reset mid-stall: state returns to RUN and the held instruction is re-presented by IF.

Decomposition:
- Shared package wisc_pkg: opcode constants (OP_ADD … OP_HLT), field bit positions, state encoding.
- One sub-module, id_decode: combinational, takes instr and produces SrcReg1/2, uses1/2, the controls, and ex_imm.
- The stage itself holds the hazard logic, state register and pipeline flops.

Test Plan:
1. ADD R3,R1,R2 with SrcData1=0x0005, SrcData2=0x0007 → next cycle: ex_valid=1, ex_op1=0x0005, ex_op2=0x0007, ex_rd=3, ex_reg_write=1, stall never 1.
2. LW R4,R1,#-2 (0x841E), then ADD R5,R4,R6 → LW cycle: ex_imm=0xFFFC. Next cycle: stall=1 and ex_valid=0. The cycle after: ADD latched with ex_rs=4, stall=0.
3. Load-use condition with flush=1 in the same cycle → stall=0, ex_valid=0 next cycle, state RUN.
4. SW R7,R2,#3 (0x9723) → SrcReg1=2, SrcReg2=7, ex_mem_write=1, ex_imm=0x0006. LHB R9,0xAB (0xB9AB) → SrcReg1=9, ex_imm=0x00AB.
5. HLT (0xF000) → halted=1 on the next edge. Later if_valid instructions are ignored; ex_valid is 0 from the following cycle.
6. Assert rst=0 asynchronously between clock edges during BUBBLE → all outputs 0 immediately. After release, the first valid instruction is latched normally.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC 16-bit pipelined CPU.
//   opcode_e : 4-bit instruction opcodes (instr[15:12])
//   *_LSB    : low bit of each instruction field (opcode, A, B, C)
//   state_e  : ID/EX stage sequencing states
package wisc_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_XOR    = 4'h2,
      OP_RED    = 4'h3,
      OP_SLL    = 4'h4,
      OP_SRA    = 4'h5,
      OP_ROR    = 4'h6,
      OP_PADDSB = 4'h7,
      OP_LW     = 4'h8,
      OP_SW     = 4'h9,
      OP_LLB    = 4'hA,
      OP_LHB    = 4'hB,
      OP_B      = 4'hC,
      OP_BR     = 4'hD,
      OP_PCS    = 4'hE,
      OP_HLT    = 4'hF
   } opcode_e;

   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned FA_LSB  = 8;
   localparam int unsigned FB_LSB  = 4;
   localparam int unsigned FC_LSB  = 0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HALT   = 2'd2
   } state_e;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder for the WISC ID stage.
//   instr            : IF/ID instruction word
//   opcode, rd       : raw opcode and field A (destination)
//   src_reg1/2       : register-file read addresses
//   uses1/2          : instruction really consumes the matching source
//   reg_write, mem_* : EX/MEM/WB controls
//   imm              : extended immediate
module id_decode
   import wisc_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 4
) (
   input  logic [DW-1:0] instr,
   output logic [3:0]    opcode,
   output logic [RW-1:0] rd,
   output logic [RW-1:0] src_reg1,
   output logic [RW-1:0] src_reg2,
   output logic          uses1,
   output logic          uses2,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic [DW-1:0] imm
);

   opcode_e       op;
   logic [RW-1:0] fa;
   logic [RW-1:0] fb;
   logic [RW-1:0] fc;

   assign op     = opcode_e'(instr[OPC_LSB +: 4]);
   assign fa     = instr[FA_LSB +: RW];
   assign fb     = instr[FB_LSB +: RW];
   assign fc     = instr[FC_LSB +: RW];
   assign opcode = instr[OPC_LSB +: 4];
   assign rd     = fa;

   always_comb begin
      // LLB/LHB read-modify-write their destination, SW reads its data from A
      src_reg1  = (op == OP_LLB || op == OP_LHB) ? fa : fb;
      src_reg2  = (op == OP_SW) ? fa : fc;
      uses1     = (op <= OP_LHB) || (op == OP_BR);
      uses2     = op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB, OP_SW};
      reg_write = (op <= OP_LW) || op inside {OP_LLB, OP_LHB, OP_PCS};
      mem_read  = (op == OP_LW);
      mem_write = (op == OP_SW);
      imm       = '0;
      case (op)
         OP_SLL, OP_SRA, OP_ROR: imm = {{(DW-RW){1'b0}}, fc};
         OP_LW, OP_SW:           imm = {{(DW-RW-1){fc[RW-1]}}, fc, 1'b0};
         OP_LLB, OP_LHB:         imm = {{(DW-8){1'b0}}, instr[7:0]};
         OP_B:                   imm = {{(DW-10){instr[8]}}, instr[8:0], 1'b0};
         default:                imm = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// WISC decode stage and ID/EX pipeline register.
//   clk, rst          : core clock; asynchronous active-low reset
//   if_valid/instr/pc : IF/ID contents (pc is PC+2)
//   flush             : branch taken in EX, kill the ID instruction
//   SrcReg1/2         : register-file read addresses (combinational)
//   SrcData1/2        : register-file read data, sampled at the latching edge
//   stall             : load-use hazard, hold PC and IF/ID this cycle
//   halted            : sticky, HLT has reached EX
//   ex_*              : registered EX-stage instruction state and controls
module id_ex_stage
   import wisc_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid,
   input  logic [DW-1:0] if_instr,
   input  logic [DW-1:0] if_pc,
   input  logic          flush,
   output logic [RW-1:0] SrcReg1,
   output logic [RW-1:0] SrcReg2,
   input  logic [DW-1:0] SrcData1,
   input  logic [DW-1:0] SrcData2,
   output logic          stall,
   output logic          halted,
   output logic          ex_valid,
   output logic [3:0]    ex_opcode,
   output logic [RW-1:0] ex_rd,
   output logic [RW-1:0] ex_rs,
   output logic [RW-1:0] ex_rt,
   output logic [DW-1:0] ex_op1,
   output logic [DW-1:0] ex_op2,
   output logic [DW-1:0] ex_imm,
   output logic [DW-1:0] ex_pc,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write
);

   logic [3:0]    dec_opcode;
   logic [RW-1:0] dec_rd;
   logic          dec_uses1;
   logic          dec_uses2;
   logic          dec_reg_write;
   logic          dec_mem_read;
   logic          dec_mem_write;
   logic [DW-1:0] dec_imm;

   id_decode #(.DW(DW), .RW(RW)) u_decode (
      .instr     (if_instr),
      .opcode    (dec_opcode),
      .rd        (dec_rd),
      .src_reg1  (SrcReg1),
      .src_reg2  (SrcReg2),
      .uses1     (dec_uses1),
      .uses2     (dec_uses2),
      .reg_write (dec_reg_write),
      .mem_read  (dec_mem_read),
      .mem_write (dec_mem_write),
      .imm       (dec_imm)
   );

   state_e        state_q, state_d;
   logic          halted_q, halted_d;
   logic          ex_valid_q, ex_valid_d;
   logic [3:0]    ex_opcode_q, ex_opcode_d;
   logic [RW-1:0] ex_rd_q, ex_rd_d;
   logic [RW-1:0] ex_rs_q, ex_rs_d;
   logic [RW-1:0] ex_rt_q, ex_rt_d;
   logic [DW-1:0] ex_op1_q, ex_op1_d;
   logic [DW-1:0] ex_op2_q, ex_op2_d;
   logic [DW-1:0] ex_imm_q, ex_imm_d;
   logic [DW-1:0] ex_pc_q, ex_pc_d;
   logic          ex_reg_write_q, ex_reg_write_d;
   logic          ex_mem_read_q, ex_mem_read_d;
   logic          ex_mem_write_q, ex_mem_write_d;
   logic          load_use;
   logic          stall_c;

   always_comb begin
      // R0 as a load target never creates a dependency worth stalling on
      load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && if_valid &&
                 ((dec_uses1 && (SrcReg1 == ex_rd_q)) ||
                  (dec_uses2 && (SrcReg2 == ex_rd_q)));
      stall_c  = load_use && !flush && (state_q == ST_RUN);

      state_d        = state_q;
      halted_d       = halted_q;
      ex_valid_d     = ex_valid_q;
      ex_opcode_d    = ex_opcode_q;
      ex_rd_d        = ex_rd_q;
      ex_rs_d        = ex_rs_q;
      ex_rt_d        = ex_rt_q;
      ex_op1_d       = ex_op1_q;
      ex_op2_d       = ex_op2_q;
      ex_imm_d       = ex_imm_q;
      ex_pc_d        = ex_pc_q;
      ex_reg_write_d = ex_reg_write_q;
      ex_mem_read_d  = ex_mem_read_q;
      ex_mem_write_d = ex_mem_write_q;

      if (state_q == ST_HALT) begin
         ex_valid_d = 1'b0;
      end else if (flush || stall_c) begin
         // flush and bubble both insert an all-zero EX slot
         ex_valid_d     = 1'b0;
         ex_opcode_d    = '0;
         ex_rd_d        = '0;
         ex_rs_d        = '0;
         ex_rt_d        = '0;
         ex_op1_d       = '0;
         ex_op2_d       = '0;
         ex_imm_d       = '0;
         ex_pc_d        = '0;
         ex_reg_write_d = 1'b0;
         ex_mem_read_d  = 1'b0;
         ex_mem_write_d = 1'b0;
         state_d        = flush ? ST_RUN : ST_BUBBLE;
      end else begin
         ex_valid_d     = if_valid;
         ex_opcode_d    = dec_opcode;
         ex_rd_d        = dec_rd;
         ex_rs_d        = SrcReg1;
         ex_rt_d        = SrcReg2;
         ex_op1_d       = SrcData1;
         ex_op2_d       = SrcData2;
         ex_imm_d       = dec_imm;
         ex_pc_d        = if_pc;
         ex_reg_write_d = dec_reg_write;
         ex_mem_read_d  = dec_mem_read;
         ex_mem_write_d = dec_mem_write;
         state_d        = ST_RUN;
         if (if_valid && (dec_opcode == OP_HLT)) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_RUN;
         halted_q       <= 1'b0;
         ex_valid_q     <= 1'b0;
         ex_opcode_q    <= '0;
         ex_rd_q        <= '0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_op1_q       <= '0;
         ex_op2_q       <= '0;
         ex_imm_q       <= '0;
         ex_pc_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         halted_q       <= halted_d;
         ex_valid_q     <= ex_valid_d;
         ex_opcode_q    <= ex_opcode_d;
         ex_rd_q        <= ex_rd_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_op1_q       <= ex_op1_d;
         ex_op2_q       <= ex_op2_d;
         ex_imm_q       <= ex_imm_d;
         ex_pc_q        <= ex_pc_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
      end
   end

   assign stall        = stall_c;
   assign halted       = halted_q;
   assign ex_valid     = ex_valid_q;
   assign ex_opcode    = ex_opcode_q;
   assign ex_rd        = ex_rd_q;
   assign ex_rs        = ex_rs_q;
   assign ex_rt        = ex_rt_q;
   assign ex_op1       = ex_op1_q;
   assign ex_op2       = ex_op2_q;
   assign ex_imm       = ex_imm_q;
   assign ex_pc        = ex_pc_q;
   assign ex_reg_write = ex_reg_write_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign ex_mem_write = ex_mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        flush;
   logic [3:0]  SrcReg1, SrcReg2;
   logic [15:0] SrcData1, SrcData2;
   logic        stall, halted, ex_valid;
   logic [3:0]  ex_opcode, ex_rd, ex_rs, ex_rt;
   logic [15:0] ex_op1, ex_op2, ex_imm, ex_pc;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;

   int n_checks = 0;
   int n_fail   = 0;

   id_ex_stage #(.DW(16), .RW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .flush        (flush),
      .SrcReg1      (SrcReg1),
      .SrcReg2      (SrcReg2),
      .SrcData1     (SrcData1),
      .SrcData2     (SrcData2),
      .stall        (stall),
      .halted       (halted),
      .ex_valid     (ex_valid),
      .ex_opcode    (ex_opcode),
      .ex_rd        (ex_rd),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_op1       (ex_op1),
      .ex_op2       (ex_op2),
      .ex_imm       (ex_imm),
      .ex_pc        (ex_pc),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [15:0] instr;
      logic [15:0] pc;
      logic        flush;
      logic [15:0] d1;
      logic [15:0] d2;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        stall;
      logic        e_valid;
      logic [3:0]  e_op;
      logic [3:0]  e_rd;
      logic [3:0]  e_rs;
      logic [3:0]  e_rt;
      logic [15:0] e_op1;
      logic [15:0] e_op2;
      logic [15:0] e_imm;
      logic [15:0] e_pc;
      logic        e_rw;
      logic        e_mr;
      logic        e_mw;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic fl, input logic [15:0] d1, input logic [15:0] d2);
      if_valid = v;
      if_instr = ins;
      if_pc    = pc;
      flush    = fl;
      SrcData1 = d1;
      SrcData2 = d2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          v    instr    pc       fl   d1       d2       s1    s2    st   ev   op    rd    rs    rt    op1      op2      imm      pc       rw   mr   mw
      vecs[0]  = '{1'b1, 16'h0312, 16'h0002, 1'b0, 16'h0005, 16'h0007, 4'h1, 4'h2, 1'b0, 1'b1, 4'h0, 4'h3, 4'h1, 4'h2, 16'h0005, 16'h0007, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 16'h841E, 16'h0004, 1'b0, 16'h1000, 16'h0033, 4'h1, 4'hE, 1'b0, 1'b1, 4'h8, 4'h4, 4'h1, 4'hE, 16'h1000, 16'h0033, 16'hFFFC, 16'h0004, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 16'h0546, 16'h0006, 1'b0, 16'h1111, 16'h2222, 4'h4, 4'h6, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 16'h0546, 16'h0006, 1'b0, 16'h0009, 16'h0002, 4'h4, 4'h6, 1'b0, 1'b1, 4'h0, 4'h5, 4'h4, 4'h6, 16'h0009, 16'h0002, 16'h0000, 16'h0006, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 16'h8231, 16'h0008, 1'b0, 16'h0100, 16'h0000, 4'h3, 4'h1, 1'b0, 1'b1, 4'h8, 4'h2, 4'h3, 4'h1, 16'h0100, 16'h0000, 16'h0002, 16'h0008, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 16'h1672, 16'h000A, 1'b1, 16'h0001, 16'h0002, 4'h7, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 16'h9723, 16'h000C, 1'b0, 16'h0040, 16'hBEEF, 4'h2, 4'h7, 1'b0, 1'b1, 4'h9, 4'h7, 4'h2, 4'h7, 16'h0040, 16'hBEEF, 16'h0006, 16'h000C, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 16'hB9AB, 16'h000E, 1'b0, 16'h1234, 16'h5555, 4'h9, 4'hB, 1'b0, 1'b1, 4'hB, 4'h9, 4'h9, 4'hB, 16'h1234, 16'h5555, 16'h00AB, 16'h000E, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 16'hC1FE, 16'h0010, 1'b0, 16'hAAAA, 16'h0000, 4'hF, 4'hE, 1'b0, 1'b1, 4'hC, 4'h1, 4'hF, 4'hE, 16'hAAAA, 16'h0000, 16'hFFFC, 16'h0010, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 16'h0123, 16'h0012, 1'b0, 16'h0003, 16'h0004, 4'h2, 4'h3, 1'b0, 1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0003, 16'h0004, 16'h0000, 16'h0012, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 16'h8010, 16'h0014, 1'b0, 16'h0020, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b1, 4'h8, 4'h0, 4'h1, 4'h0, 16'h0020, 16'h0000, 16'h0000, 16'h0014, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 16'h0100, 16'h0016, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0016, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 16'h4235, 16'h0018, 1'b0, 16'h0F0F, 16'h7777, 4'h3, 4'h5, 1'b0, 1'b1, 4'h4, 4'h2, 4'h3, 4'h5, 16'h0F0F, 16'h7777, 16'h0005, 16'h0018, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 16'h8510, 16'h001A, 1'b0, 16'h0001, 16'h0002, 4'h1, 4'h0, 1'b0, 1'b1, 4'h8, 4'h5, 4'h1, 4'h0, 16'h0001, 16'h0002, 16'h0000, 16'h001A, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 16'h4235, 16'h001C, 1'b0, 16'h0003, 16'h0004, 4'h3, 4'h5, 1'b0, 1'b1, 4'h4, 4'h2, 4'h3, 4'h5, 16'h0003, 16'h0004, 16'h0005, 16'h001C, 1'b1, 1'b0, 1'b0};

      rst = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      #12;
      chk("reset.ex_valid", {15'd0, ex_valid}, 16'h0000);
      chk("reset.halted",   {15'd0, halted},   16'h0000);
      chk("reset.stall",    {15'd0, stall},    16'h0000);
      chk("reset.ex_pc",    ex_pc,             16'h0000);
      chk("reset.ex_op1",   ex_op1,            16'h0000);
      #1 rst = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].d1, vecs[i].d2);
         #3;
         chk($sformatf("v%0d.SrcReg1", i), {12'd0, SrcReg1}, {12'd0, vecs[i].s1});
         chk($sformatf("v%0d.SrcReg2", i), {12'd0, SrcReg2}, {12'd0, vecs[i].s2});
         chk($sformatf("v%0d.stall", i),   {15'd0, stall},   {15'd0, vecs[i].stall});
         tick();
         chk($sformatf("v%0d.ex_valid", i),  {15'd0, ex_valid},     {15'd0, vecs[i].e_valid});
         chk($sformatf("v%0d.ex_opcode", i), {12'd0, ex_opcode},    {12'd0, vecs[i].e_op});
         chk($sformatf("v%0d.ex_rd", i),     {12'd0, ex_rd},        {12'd0, vecs[i].e_rd});
         chk($sformatf("v%0d.ex_rs", i),     {12'd0, ex_rs},        {12'd0, vecs[i].e_rs});
         chk($sformatf("v%0d.ex_rt", i),     {12'd0, ex_rt},        {12'd0, vecs[i].e_rt});
         chk($sformatf("v%0d.ex_op1", i),    ex_op1,                vecs[i].e_op1);
         chk($sformatf("v%0d.ex_op2", i),    ex_op2,                vecs[i].e_op2);
         chk($sformatf("v%0d.ex_imm", i),    ex_imm,                vecs[i].e_imm);
         chk($sformatf("v%0d.ex_pc", i),     ex_pc,                 vecs[i].e_pc);
         chk($sformatf("v%0d.ex_reg_write", i), {15'd0, ex_reg_write}, {15'd0, vecs[i].e_rw});
         chk($sformatf("v%0d.ex_mem_read", i),  {15'd0, ex_mem_read},  {15'd0, vecs[i].e_mr});
         chk($sformatf("v%0d.ex_mem_write", i), {15'd0, ex_mem_write}, {15'd0, vecs[i].e_mw});
         chk($sformatf("v%0d.halted", i),    {15'd0, halted},       16'h0000);
      end

      // Asynchronous reset while the stage sits in BUBBLE
      drive(1'b1, 16'h841E, 16'h0030, 1'b0, 16'h2000, 16'h0000);
      tick();
      chk("rb.lw_mem_read", {15'd0, ex_mem_read}, 16'h0001);
      drive(1'b1, 16'h0546, 16'h0032, 1'b0, 16'h0077, 16'h0088);
      #3;
      chk("rb.stall", {15'd0, stall}, 16'h0001);
      tick();
      chk("rb.bubble_valid", {15'd0, ex_valid}, 16'h0000);
      #1 rst = 1'b0;
      #1;
      chk("rb.async_ex_valid",    {15'd0, ex_valid},    16'h0000);
      chk("rb.async_ex_mem_read", {15'd0, ex_mem_read}, 16'h0000);
      chk("rb.async_stall",       {15'd0, stall},       16'h0000);
      @(posedge clk);
      #2 rst = 1'b1;
      tick();
      chk("rb.relatch_valid", {15'd0, ex_valid}, 16'h0001);
      chk("rb.relatch_rs",    {12'd0, ex_rs},    16'h0004);
      chk("rb.relatch_rd",    {12'd0, ex_rd},    16'h0005);
      chk("rb.relatch_op1",   ex_op1,            16'h0077);
      chk("rb.relatch_pc",    ex_pc,             16'h0032);

      // HLT reaches EX, later instructions are ignored
      drive(1'b1, 16'hF000, 16'h0020, 1'b0, 16'h0000, 16'h0000);
      #3;
      chk("hlt.stall", {15'd0, stall}, 16'h0000);
      tick();
      chk("hlt.halted",    {15'd0, halted},       16'h0001);
      chk("hlt.ex_valid",  {15'd0, ex_valid},     16'h0001);
      chk("hlt.ex_opcode", {12'd0, ex_opcode},    16'h000F);
      chk("hlt.ex_rw",     {15'd0, ex_reg_write}, 16'h0000);
      drive(1'b1, 16'h0312, 16'h0022, 1'b0, 16'h0005, 16'h0007);
      tick();
      chk("hlt1.ex_valid",  {15'd0, ex_valid},  16'h0000);
      chk("hlt1.halted",    {15'd0, halted},    16'h0001);
      chk("hlt1.ex_opcode", {12'd0, ex_opcode}, 16'h000F);
      chk("hlt1.ex_pc",     ex_pc,              16'h0020);
      chk("hlt1.ex_op1",    ex_op1,             16'h0000);
      drive(1'b1, 16'h841E, 16'h0024, 1'b0, 16'h1234, 16'h0000);
      #3;
      chk("hlt2.stall", {15'd0, stall}, 16'h0000);
      tick();
      chk("hlt2.ex_valid",    {15'd0, ex_valid},    16'h0000);
      chk("hlt2.ex_mem_read", {15'd0, ex_mem_read}, 16'h0000);
      chk("hlt2.ex_pc",       ex_pc,                16'h0020);

      // Asynchronous reset out of HALT, then normal operation resumes
      #1 rst = 1'b0;
      #1;
      chk("hr.async_halted",    {15'd0, halted},    16'h0000);
      chk("hr.async_ex_opcode", {12'd0, ex_opcode}, 16'h0000);
      chk("hr.async_ex_pc",     ex_pc,              16'h0000);
      @(posedge clk);
      #2 rst = 1'b1;
      drive(1'b1, 16'h0312, 16'h0026, 1'b0, 16'h0005, 16'h0007);
      tick();
      chk("hr.ex_valid", {15'd0, ex_valid}, 16'h0001);
      chk("hr.ex_rd",    {12'd0, ex_rd},    16'h0003);
      chk("hr.ex_op1",   ex_op1,            16'h0005);
      chk("hr.ex_op2",   ex_op2,            16'h0007);
      chk("hr.ex_pc",    ex_pc,             16'h0026);
      chk("hr.halted",   {15'd0, halted},   16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
